// File: rtl/switch_onehot_pipe_pkg.sv
// Shared types and helpers for the one-hot crossbar.
// packet_t mirrors the NoC payload type from the shared config.
package switch_onehot_pipe_pkg;

    localparam int PKT_W      = 8;
    localparam int STAGES_MAX = 4;
    localparam int SEL_MAX    = 16;

    typedef logic [PKT_W-1:0] packet_t;

    typedef struct packed {
        logic       zero;
        logic       one;
        logic       multi;
        logic [3:0] idx;
    } onehot_t;

    // Classify a select vector; idx is only meaningful when one is set.
    function automatic onehot_t onehot_status(input logic [SEL_MAX-1:0] sel);
        onehot_t     r;
        int unsigned cnt;
        r   = '0;
        cnt = 0;
        for (int j = 0; j < SEL_MAX; j++) begin
            if (sel[j]) begin
                cnt++;
                r.idx = 4'(j);
            end
        end
        r.zero  = (cnt == 0);
        r.one   = (cnt == 1);
        r.multi = (cnt > 1);
        return r;
    endfunction

endpackage

// File: rtl/switch_onehot_pipe_lane.sv
// One crossbar output: one-hot mux, output pipeline and saturating
// multi-hot error counter.
module switch_onehot_lane
    import switch_onehot_pipe_pkg::*;
#(
    parameter int N         = 5,
    parameter int STAGES    = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [0:N-1]         sel,
    input  packet_t [0:N-1]      data,
    input  logic [0:N-1]         valid,
    input  logic                 err_clr,
    output packet_t              lane_data,
    output logic                 lane_valid,
    output logic                 lane_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef struct packed {
        packet_t data;
        logic    err;
    } slot_t;

    logic [SEL_MAX-1:0] sel_w;
    onehot_t            st;
    packet_t            s0_data;
    logic               s0_valid;
    logic               s0_err;

    always_comb begin
        sel_w = '0;
        for (int j = 0; j < N; j++) sel_w[j] = sel[j];
    end

    assign st = onehot_status(sel_w);

    // Multi-hot selects are flagged and never OR-merged onto the output.
    always_comb begin
        s0_data  = '0;
        s0_valid = 1'b0;
        s0_err   = 1'b0;
        if (st.zero) begin
            s0_err = 1'b0;
        end else if (st.one) begin
            for (int j = 0; j < N; j++) begin
                if (st.idx == 4'(j)) begin
                    s0_data  = data[j];
                    s0_valid = valid[j];
                end
            end
        end else if (st.multi) begin
            s0_err = 1'b1;
        end
    end

    if (STAGES == 0) begin : g_comb
        assign lane_data  = s0_data;
        assign lane_valid = s0_valid;
        assign lane_err   = s0_err;
    end else begin : g_regs
        slot_t             pipe [1:STAGES];
        logic [STAGES:1]   vld_pipe;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 1; k <= STAGES; k++) pipe[k] <= '0;
                vld_pipe <= '0;
            end else if (en) begin
                pipe[1]     <= '{data: s0_data, err: s0_err};
                vld_pipe[1] <= s0_valid;
                for (int k = 2; k <= STAGES; k++) begin
                    pipe[k]     <= pipe[k-1];
                    vld_pipe[k] <= vld_pipe[k-1];
                end
            end
        end

        assign lane_data  = pipe[STAGES].data;
        assign lane_valid = vld_pipe[STAGES];
        assign lane_err   = pipe[STAGES].err;
    end

    // Counter tracks stage 0 directly so it is independent of pipeline depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (en && s0_err && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
    end

endmodule

// File: rtl/switch_onehot_pipe.sv
// NxM one-hot crossbar with output pipeline, stall and per-output
// select-error detection; one lane per output.
module switch_onehot_pipe
    import switch_onehot_pipe_pkg::*;
#(
    parameter int N         = 5,
    parameter int M         = 5,
    parameter int STAGES    = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_en,
    input  logic [0:M-1][0:N-1]            i_sel,
    input  packet_t [0:N-1]                i_data,
    input  logic [0:N-1]                   i_valid,
    input  logic                           i_err_clr,
    output packet_t [0:M-1]                o_data,
    output logic [0:M-1]                   o_valid,
    output logic [0:M-1]                   o_sel_err,
    output logic [0:M-1][ERR_CNT_W-1:0]    o_err_cnt
);

    if (STAGES > STAGES_MAX) begin : g_bad_stages
        $error("switch_onehot_pipe: STAGES exceeds STAGES_MAX");
    end

    for (genvar i = 0; i < M; i++) begin : g_lane
        switch_onehot_lane #(
            .N         (N),
            .STAGES    (STAGES),
            .ERR_CNT_W (ERR_CNT_W)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .en         (i_en),
            .sel        (i_sel[i]),
            .data       (i_data),
            .valid      (i_valid),
            .err_clr    (i_err_clr),
            .lane_data  (o_data[i]),
            .lane_valid (o_valid[i]),
            .lane_err   (o_sel_err[i]),
            .err_cnt    (o_err_cnt[i])
        );
    end

endmodule

// File: tb/tb_switch_onehot_pipe.sv
// Bench: two crossbar instances (STAGES=2/W=8 and STAGES=3/W=2) on shared
// inputs, checked against a queue-based model plus directed vectors.
module tb_switch_onehot_pipe;
    import switch_onehot_pipe_pkg::*;

    localparam int N = 5, M = 5, SA = 2, SB = 3, WA = 8, WB = 2;

    logic clk = 1'b0;
    logic reset_n, en, clr;
    logic [0:M-1][0:N-1] sel;
    packet_t [0:N-1]     din;
    logic [0:N-1]        vin;

    packet_t [0:M-1]       a_data, b_data;
    logic [0:M-1]          a_valid, b_valid, a_err, b_err;
    logic [0:M-1][WA-1:0]  a_cnt;
    logic [0:M-1][WB-1:0]  b_cnt;

    always #5 clk = ~clk;

    switch_onehot_pipe #(.N(N), .M(M), .STAGES(SA), .ERR_CNT_W(WA)) u_a (
        .clk(clk), .reset_n(reset_n), .i_en(en), .i_sel(sel), .i_data(din),
        .i_valid(vin), .i_err_clr(clr), .o_data(a_data), .o_valid(a_valid),
        .o_sel_err(a_err), .o_err_cnt(a_cnt));

    switch_onehot_pipe #(.N(N), .M(M), .STAGES(SB), .ERR_CNT_W(WB)) u_b (
        .clk(clk), .reset_n(reset_n), .i_en(en), .i_sel(sel), .i_data(din),
        .i_valid(vin), .i_err_clr(clr), .o_data(b_data), .o_valid(b_valid),
        .o_sel_err(b_err), .o_err_cnt(b_cnt));

    // Reference model: history of per-output results of each enabled cycle.
    typedef struct packed {
        logic [0:M-1][7:0] d;
        logic [0:M-1]      v;
        logic [0:M-1]      e;
    } snap_t;

    snap_t hist[$];
    int    cnt_a[M], cnt_b[M];
    int    errors = 0, checks = 0;

    function automatic snap_t stage0();
        snap_t s;
        int    c;
        s = '0;
        for (int i = 0; i < M; i++) begin
            c = $countones(sel[i]);
            if (c == 1) begin
                for (int j = 0; j < N; j++)
                    if (sel[i][j]) begin
                        s.d[i] = din[j];
                        s.v[i] = vin[j];
                    end
            end else if (c > 1) begin
                s.e[i] = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic model_edge();
        snap_t s;
        s = stage0();
        for (int i = 0; i < M; i++) begin
            if (clr) begin
                cnt_a[i] = 0;
                cnt_b[i] = 0;
            end else if (en && s.e[i]) begin
                cnt_a[i] = (cnt_a[i] < 255) ? cnt_a[i] + 1 : 255;
                cnt_b[i] = (cnt_b[i] < 3) ? cnt_b[i] + 1 : 3;
            end
        end
        if (en) begin
            hist.push_back(s);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < M; i++) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
        end
    endtask

    function automatic snap_t expect_snap(int s);
        if (hist.size() < s) return '0;
        return hist[hist.size() - s];
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %0h expected %0h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic check_all();
        snap_t ea, eb;
        ea = expect_snap(SA);
        eb = expect_snap(SB);
        for (int i = 0; i < M; i++) begin
            chk("a_data",  i, 32'(a_data[i]),  32'(ea.d[i]));
            chk("a_valid", i, 32'(a_valid[i]), 32'(ea.v[i]));
            chk("a_err",   i, 32'(a_err[i]),   32'(ea.e[i]));
            chk("a_cnt",   i, 32'(a_cnt[i]),   32'(cnt_a[i]));
            chk("b_data",  i, 32'(b_data[i]),  32'(eb.d[i]));
            chk("b_valid", i, 32'(b_valid[i]), 32'(eb.v[i]));
            chk("b_err",   i, 32'(b_err[i]),   32'(eb.e[i]));
            chk("b_cnt",   i, 32'(b_cnt[i]),   32'(cnt_b[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_idle();
        sel = '0; din = '0; vin = '0; en = 1'b1; clr = 1'b0;
    endtask

    // Directed vectors for instance A (STAGES=2); expectations worked by hand.
    typedef struct {
        logic [0:M-1][0:N-1] s;
        logic [0:N-1][7:0]   d;
        logic [0:N-1]        v;
        logic                e;
        logic                c;
        int                  o;
        logic [7:0]          xd;
        logic                xv;
        logic                xe;
        int                  xc;
    } vec_t;

    function automatic vec_t mk(logic [0:M-1][0:N-1] s, logic [0:N-1][7:0] d,
                                logic [0:N-1] v, logic e, logic c, int o,
                                logic [7:0] xd, logic xv, logic xe, int xc);
        vec_t r;
        r.s = s; r.d = d; r.v = v; r.e = e; r.c = c; r.o = o;
        r.xd = xd; r.xv = xv; r.xe = xe; r.xc = xc;
        return r;
    endfunction

    localparam logic [0:M-1][0:N-1] S_IDLE = '0;
    localparam logic [0:M-1][0:N-1] S_T1   = {5'b00100, 20'd0};
    localparam logic [0:M-1][0:N-1] S_BC   = {5{5'b10000}};
    localparam logic [0:M-1][0:N-1] S_MH   = {5'b00000, 5'b01010, 15'd0};
    localparam logic [0:N-1][7:0]   D_T1   = {8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
    localparam logic [0:N-1][7:0]   D_BC   = {8'h3C, 32'h0};

    vec_t tbl[14];

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] feed [10];
        logic       fen  [10];
        logic       fvl  [10];
        logic [7:0] got[$];
        int         k2;

        tbl[0]  = mk(S_T1,   D_T1, 5'b00100, 1, 0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(S_IDLE, '0,   '0,       1, 0, 0, 8'hA5, 1, 0, 0);
        tbl[2]  = mk(S_IDLE, '0,   '0,       1, 0, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(S_BC,   D_BC, 5'b10000, 1, 0, 4, 8'h00, 0, 0, 0);
        tbl[4]  = mk(S_IDLE, '0,   '0,       1, 0, 4, 8'h3C, 1, 0, 0);
        tbl[5]  = mk(S_IDLE, '0,   '0,       1, 0, 2, 8'h00, 0, 0, 0);
        tbl[6]  = mk(S_MH,   '0,   '0,       1, 0, 1, 8'h00, 0, 0, 1);
        tbl[7]  = mk(S_MH,   '0,   '0,       1, 0, 1, 8'h00, 0, 1, 2);
        tbl[8]  = mk(S_MH,   '0,   '0,       1, 0, 1, 8'h00, 0, 1, 3);
        tbl[9]  = mk(S_MH,   '0,   '0,       1, 1, 1, 8'h00, 0, 1, 0);
        tbl[10] = mk(S_IDLE, '0,   '0,       1, 0, 1, 8'h00, 0, 1, 0);
        tbl[11] = mk(S_IDLE, '0,   '0,       1, 0, 1, 8'h00, 0, 0, 0);
        tbl[12] = mk(S_MH,   '0,   '0,       0, 0, 1, 8'h00, 0, 0, 0);
        tbl[13] = mk(S_IDLE, '0,   '0,       1, 0, 1, 8'h00, 0, 0, 0);

        // Reset state
        set_idle();
        reset_n = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table
        for (int r = 0; r < 14; r++) begin
            sel = tbl[r].s; din = tbl[r].d; vin = tbl[r].v;
            en = tbl[r].e; clr = tbl[r].c;
            cycle();
            chk("tbl_data",  r, 32'(a_data[tbl[r].o]),  32'(tbl[r].xd));
            chk("tbl_valid", r, 32'(a_valid[tbl[r].o]), 32'(tbl[r].xv));
            chk("tbl_err",   r, 32'(a_err[tbl[r].o]),   32'(tbl[r].xe));
            chk("tbl_cnt",   r, 32'(a_cnt[tbl[r].o]),   32'(tbl[r].xc));
        end

        // Stall through instance B (STAGES=3): 01..03, two stall cycles, 04
        set_idle();
        for (int k = 0; k < 4; k++) cycle();
        feed = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        fen  = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        fvl  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        k2 = -1;
        for (int k = 0; k < 10; k++) begin
            sel = S_BC; din = '0; din[0] = feed[k]; vin = '0; vin[0] = fvl[k];
            en = fen[k];
            cycle();
            if (fen[k] && b_valid[0]) begin
                got.push_back(b_data[0]);
                if (got.size() == 2) k2 = k;
            end
            if (!fen[k]) begin
                chk("stall_hold_data",  k, 32'(b_data[0]),  32'h01);
                chk("stall_hold_valid", k, 32'(b_valid[0]), 32'h1);
            end
        end
        chk("stall_count", 0, 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("stall_order", i, 32'(got[i]), 32'(i + 1));
        chk("stall_latency", 2, 32'(k2), 32'd5);

        // Saturation: 6 multi-hot cycles on output 2
        set_idle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        sel = {10'd0, 5'b11000, 10'd0};
        for (int k = 0; k < 6; k++) cycle();
        chk("sat_b", 2, 32'(b_cnt[2]), 32'd3);
        chk("sat_a", 2, 32'(a_cnt[2]), 32'd6);
        cycle();
        chk("sat_b_hold", 2, 32'(b_cnt[2]), 32'd3);

        // Reset with packets in every stage
        set_idle();
        for (int i = 0; i < M; i++) sel[i][i] = 1'b1;
        vin = '1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < N; j++) din[j] = 8'(8'h10 * (k + 1) + j);
            cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_valid_a", 0, 32'(a_valid), 32'd0);
        chk("rst_valid_b", 0, 32'(b_valid), 32'd0);
        @(negedge clk);
        set_idle();
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("post_rst_valid", k, 32'(a_valid | b_valid), 32'd0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < M; i++) begin
                int mode, j1, j2;
                mode = $urandom_range(0, 3);
                j1 = $urandom_range(0, N - 1);
                j2 = (j1 + $urandom_range(1, N - 1)) % N;
                sel[i] = '0;
                if (mode == 1 || mode == 2) sel[i][j1] = 1'b1;
                else if (mode == 3) begin
                    sel[i][j1] = 1'b1;
                    sel[i][j2] = 1'b1;
                end
            end
            for (int j = 0; j < N; j++) din[j] = 8'($urandom);
            vin = 5'($urandom);
            en  = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
